// File: rtl/lcd_char_writer_pkg.sv
// Shared definitions for the HD44780 character writer: command codes,
// FSM encodings, the job descriptor and the power-on/config sequence table.
package lcd_char_writer_pkg;

    // Wide enough for the longest wait (power-on, 750000 cycles at 50 MHz)
    localparam int unsigned DLY_W = 20;
    // Nibble transmitter counter covers setup/enable/hold
    localparam int unsigned TXC_W = 8;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned COL_W = 5;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h28;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
    localparam logic [7:0] LCD_INIT_8BIT   = 8'h30;
    localparam logic [7:0] LCD_INIT_4BIT   = 8'h20;

    // Steps 0..7 are the init/config sequence; SEQ_DONE means user mode
    localparam logic [STEP_W-1:0] SEQ_LAST = STEP_W'(7);
    localparam logic [STEP_W-1:0] SEQ_DONE = STEP_W'(8);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_NIB_WAIT,
        S_NGAP,
        S_POST,
        S_IDLE
    } state_e;

    typedef enum logic [1:0] {
        N_IDLE,
        N_SETUP,
        N_EN,
        N_HOLD
    } nib_state_e;

    typedef enum logic [1:0] {
        W_40US,
        W_100US,
        W_4100US,
        W_1640US
    } wait_e;

    // One transfer: a single high nibble (init) or a full byte
    typedef struct packed {
        logic       single;
        logic       rs;
        logic [7:0] code;
        wait_e      wsel;
    } job_t;

    function automatic job_t cmd_job(input logic [7:0] code, input wait_e wsel);
        job_t j;
        j.single = 1'b0;
        j.rs     = 1'b0;
        j.code   = code;
        j.wsel   = wsel;
        return j;
    endfunction

    function automatic job_t nib_job(input logic [7:0] code, input wait_e wsel);
        job_t j;
        j.single = 1'b1;
        j.rs     = 1'b0;
        j.code   = code;
        j.wsel   = wsel;
        return j;
    endfunction

    // Power-on sequence: four bare nibbles then four configuration bytes
    function automatic job_t init_job(input logic [STEP_W-1:0] step);
        job_t j;
        case (step)
            STEP_W'(0): j = nib_job(LCD_INIT_8BIT, W_4100US);
            STEP_W'(1): j = nib_job(LCD_INIT_8BIT, W_100US);
            STEP_W'(2): j = nib_job(LCD_INIT_8BIT, W_40US);
            STEP_W'(3): j = nib_job(LCD_INIT_4BIT, W_40US);
            STEP_W'(4): j = cmd_job(LCD_CMD_FUNCSET, W_40US);
            STEP_W'(5): j = cmd_job(LCD_CMD_ENTRY, W_40US);
            STEP_W'(6): j = cmd_job(LCD_CMD_DISPON, W_40US);
            default:    j = cmd_job(LCD_CMD_CLEAR, W_1640US);
        endcase
        return j;
    endfunction

endpackage

// File: rtl/lcd_char_writer_nibble_tx.sv
// lcd_nibble_tx: drives one {RS, nibble} onto the LCD bus with setup,
// enable-pulse and hold timing, then pulses done for one cycle.
// Ports: clk, rst (async, active-high); start/req_rs/req_nib request;
//        done completion pulse; e/rs/nib registered LCD pins.
module lcd_nibble_tx
    import lcd_char_writer_pkg::*;
#(
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_SETUP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req_rs,
    input  logic [3:0] req_nib,
    output logic       done,
    output logic       e,
    output logic       rs,
    output logic [3:0] nib
);

    nib_state_e        state_q, state_d;
    logic [TXC_W-1:0]  cnt_q, cnt_d;
    logic              e_q, e_d;
    logic              rs_q, rs_d;
    logic [3:0]        nib_q, nib_d;
    logic              done_q, done_d;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= N_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            nib_q   <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            nib_q   <= nib_d;
            done_q  <= done_d;
        end
    end

    // RS/data only load in N_IDLE, so they never move while E is high or as it falls
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        nib_d   = nib_q;
        done_d  = 1'b0;
        case (state_q)
            N_IDLE: begin
                if (start) begin
                    rs_d    = req_rs;
                    nib_d   = req_nib;
                    cnt_d   = TXC_W'(T_SETUP - 1);
                    state_d = N_SETUP;
                end
            end
            N_SETUP: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b1;
                    cnt_d   = TXC_W'(T_EN - 1);
                    state_d = N_EN;
                end else begin
                    cnt_d = cnt_q - TXC_W'(1);
                end
            end
            N_EN: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b0;
                    cnt_d   = TXC_W'(T_SETUP - 1);
                    state_d = N_HOLD;
                end else begin
                    cnt_d = cnt_q - TXC_W'(1);
                end
            end
            N_HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = N_IDLE;
                end else begin
                    cnt_d = cnt_q - TXC_W'(1);
                end
            end
            default: state_d = N_IDLE;
        endcase
    end

    assign done = done_q;
    assign e    = e_q;
    assign rs   = rs_q;
    assign nib  = nib_q;

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: accepts one ASCII byte per write and sends it to an
// HD44780 LCD over the 4-bit bus, after running the power-on init itself.
// Ports: clk, rst (async, active-high); data/write byte input with ready
//        handshake; lcd_enabled, lcd_register_select, lcd_read_write,
//        lcd_strataflash_control, lcd_data drive the LCD / shared bus.
// Optional: define LCD_AUTOWRAP_EN to track the column and insert line-2 /
//           line-1 address commands after the 16th / 32nd character.
module lcd_char_writer
    import lcd_char_writer_pkg::*;
#(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_4100US  = 205000,
    parameter int unsigned T_100US   = 5000,
    parameter int unsigned T_40US    = 2000,
    parameter int unsigned T_1640US  = 82000,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_NGAP    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       write,
    output logic       ready,
    output logic       lcd_enabled,
    output logic       lcd_register_select,
    output logic       lcd_read_write,
    output logic       lcd_strataflash_control,
    output logic [3:0] lcd_data
);

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [7:0]         code_q, code_d;
    logic               rs_q, rs_d;
    logic               single_q, single_d;
    logic               lo_q, lo_d;
    wait_e              wsel_q, wsel_d;
    logic               tx_start_q, tx_start_d;
    logic               tx_rs_q, tx_rs_d;
    logic [3:0]         tx_nib_q, tx_nib_d;
    logic               ready_q, ready_d;
    logic               tx_done;
    logic               launch;
    job_t               job;
`ifdef LCD_AUTOWRAP_EN
    logic [COL_W-1:0]   col_q, col_d;
`endif

    function automatic logic [DLY_W-1:0] wait_load(input wait_e w);
        case (w)
            W_100US:  return DLY_W'(T_100US - 1);
            W_4100US: return DLY_W'(T_4100US - 1);
            W_1640US: return DLY_W'(T_1640US - 1);
            default:  return DLY_W'(T_40US - 1);
        endcase
    endfunction

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_PWR_WAIT;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            step_q     <= '0;
            code_q     <= 8'h00;
            rs_q       <= 1'b0;
            single_q   <= 1'b0;
            lo_q       <= 1'b0;
            wsel_q     <= W_40US;
            tx_start_q <= 1'b0;
            tx_rs_q    <= 1'b0;
            tx_nib_q   <= 4'h0;
            ready_q    <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            col_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            step_q     <= step_d;
            code_q     <= code_d;
            rs_q       <= rs_d;
            single_q   <= single_d;
            lo_q       <= lo_d;
            wsel_q     <= wsel_d;
            tx_start_q <= tx_start_d;
            tx_rs_q    <= tx_rs_d;
            tx_nib_q   <= tx_nib_d;
            ready_q    <= ready_d;
`ifdef LCD_AUTOWRAP_EN
            col_q      <= col_d;
`endif
        end
    end

    // Sequencer: every transfer starts via 'launch', which loads the job
    // and kicks the nibble transmitter with its high nibble
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        step_d     = step_q;
        code_d     = code_q;
        rs_d       = rs_q;
        single_d   = single_q;
        lo_d       = lo_q;
        wsel_d     = wsel_q;
        tx_start_d = 1'b0;
        tx_rs_d    = tx_rs_q;
        tx_nib_d   = tx_nib_q;
        launch     = 1'b0;
        job        = '0;
`ifdef LCD_AUTOWRAP_EN
        col_d      = col_q;
`endif
        case (state_q)
            S_PWR_WAIT: begin
                // Counter is zero out of reset; the first cycle arms it
                if (!armed_q) begin
                    armed_d = 1'b1;
                    cnt_d   = DLY_W'(T_POWERON - 1);
                end else if (cnt_q == '0) begin
                    launch = 1'b1;
                    job    = init_job(step_q);
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_NIB_WAIT: begin
                if (tx_done) begin
                    if (!single_q && !lo_q) begin
                        cnt_d   = DLY_W'(T_NGAP - 1);
                        state_d = S_NGAP;
                    end else begin
                        cnt_d   = wait_load(wsel_q);
                        state_d = S_POST;
                    end
                end
            end
            S_NGAP: begin
                if (cnt_q == '0) begin
                    tx_start_d = 1'b1;
                    tx_rs_d    = rs_q;
                    tx_nib_d   = code_q[3:0];
                    lo_d       = 1'b1;
                    state_d    = S_NIB_WAIT;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_POST: begin
                if (cnt_q == '0) begin
                    if (step_q != SEQ_DONE) begin
                        step_d = step_q + STEP_W'(1);
                        if (step_q == SEQ_LAST) begin
                            state_d = S_IDLE;
`ifdef LCD_AUTOWRAP_EN
                            col_d   = '0;
`endif
                        end else begin
                            launch = 1'b1;
                            job    = init_job(step_q + STEP_W'(1));
                        end
                    end else begin
                        state_d = S_IDLE;
`ifdef LCD_AUTOWRAP_EN
                        // Only characters advance the column; inserted commands do not
                        if (rs_q) begin
                            col_d = col_q + COL_W'(1);
                            if (col_q == COL_W'(15)) begin
                                launch = 1'b1;
                                job    = cmd_job(LCD_CMD_LINE2, W_40US);
                            end else if (col_q == COL_W'(31)) begin
                                col_d  = '0;
                                launch = 1'b1;
                                job    = cmd_job(LCD_CMD_LINE1, W_40US);
                            end
                        end
`endif
                    end
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_IDLE: begin
                if (write) begin
                    launch     = 1'b1;
                    job.single = 1'b0;
                    job.rs     = 1'b1;
                    job.code   = data;
                    job.wsel   = W_40US;
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase

        if (launch) begin
            code_d     = job.code;
            rs_d       = job.rs;
            single_d   = job.single;
            wsel_d     = job.wsel;
            lo_d       = 1'b0;
            tx_start_d = 1'b1;
            tx_rs_d    = job.rs;
            tx_nib_d   = job.code[7:4];
            state_d    = S_NIB_WAIT;
        end

        ready_d = (state_d == S_IDLE);
    end

    lcd_nibble_tx #(
        .T_EN    (T_EN),
        .T_SETUP (T_SETUP)
    ) u_nibble_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start_q),
        .req_rs  (tx_rs_q),
        .req_nib (tx_nib_q),
        .done    (tx_done),
        .e       (lcd_enabled),
        .rs      (lcd_register_select),
        .nib     (lcd_data)
    );

    assign ready                   = ready_q;
    assign lcd_read_write          = 1'b0;
    assign lcd_strataflash_control = 1'b1;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with shortened timing parameters.
module tb_lcd_char_writer;

    localparam int unsigned P_POWERON = 40;
    localparam int unsigned P_4100US  = 20;
    localparam int unsigned P_100US   = 10;
    localparam int unsigned P_40US    = 8;
    localparam int unsigned P_1640US  = 30;
    localparam int unsigned P_EN      = 3;
    localparam int unsigned P_SETUP   = 2;
    localparam int unsigned P_NGAP    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       write;
    logic       ready;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_sf;
    logic [3:0] lcd_data;

    always #5 clk = ~clk;

    lcd_char_writer #(
        .T_POWERON (P_POWERON),
        .T_4100US  (P_4100US),
        .T_100US   (P_100US),
        .T_40US    (P_40US),
        .T_1640US  (P_1640US),
        .T_EN      (P_EN),
        .T_SETUP   (P_SETUP),
        .T_NGAP    (P_NGAP)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .data                    (wdata),
        .write                   (write),
        .ready                   (ready),
        .lcd_enabled             (lcd_e),
        .lcd_register_select     (lcd_rs),
        .lcd_read_write          (lcd_rw),
        .lcd_strataflash_control (lcd_sf),
        .lcd_data                (lcd_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs {RS,nibble} per E pulse, checks width and stability
    logic [4:0] pulses[$];
    int         rise_cyc[$];
    int         fall_cyc[$];
    logic       prev_e = 1'b0;
    int         e_len = 0;
    logic [4:0] held = 5'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_e = 1'b0;
            e_len  = 0;
        end else begin
            if (lcd_e) begin
                if (!prev_e) begin
                    held = {lcd_rs, lcd_data};
                    pulses.push_back(held);
                    rise_cyc.push_back(cyc);
                    chk("rw_low", 32'(lcd_rw), 32'd0);
                    chk("sf_high", 32'(lcd_sf), 32'd1);
                end else begin
                    chk("bus_stable", 32'({lcd_rs, lcd_data}), 32'(held));
                end
                e_len++;
            end else if (prev_e) begin
                chk("e_width", 32'(e_len), 32'(P_EN));
                fall_cyc.push_back(cyc);
                e_len = 0;
            end
            prev_e = lcd_e;
        end
    end

    logic [4:0] expq[$];
    logic [4:0] init_seq [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                  5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};

    task automatic build_init();
        expq.delete();
        for (int i = 0; i < 12; i++) expq.push_back(init_seq[i]);
    endtask

    task automatic cmp_pulses(input string tag, input int base);
        chk({tag, "_count"}, 32'(pulses.size() - base), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (base + i < pulses.size())
                chk($sformatf("%s_p%0d", tag, i), 32'(pulses[base + i]), 32'(expq[i]));
        end
    endtask

    function automatic int last_fall();
        if (fall_cyc.size() == 0) return -1000;
        return fall_cyc[fall_cyc.size() - 1];
    endfunction

    task automatic wait_ready(input string tag, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ready) begin
                at = cyc;
                break;
            end
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    // Call at a negedge with ready=1; returns cycle index of the accepting edge
    task automatic write_byte(input string tag, input logic [7:0] b, output int acc);
        write = 1'b1;
        wdata = b;
        @(negedge clk);
        write = 1'b0;
        acc   = cyc;
        chk(tag, 32'(ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        int rc;
        logic toggle;

        rst   = 1'b1;
        write = 1'b0;
        wdata = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_sf", 32'(lcd_sf), 32'd1);
        rst = 1'b0;

        // Power-on init sequence
        base = pulses.size();
        wait_ready("init_ready", 3000, rc);
        build_init();
        cmp_pulses("init", base);
        chk("init_ready_gap", 32'(rc - last_fall()), 32'(P_SETUP + 1 + P_1640US));

        // Single character 'H'
        base = pulses.size();
        write_byte("h_busy", 8'h48, acc);
        wait_ready("h_ready", 500, rc);
        expq = '{5'h14, 5'h18};
        cmp_pulses("h", base);
        if (rise_cyc.size() > base)
            chk("h_latency", 32'(rise_cyc[base] - acc), 32'(P_SETUP + 1));
        chk("h_busy_gap", 32'(rc - last_fall()), 32'(P_SETUP + 1 + P_40US));
        if (rise_cyc.size() > base + 1 && fall_cyc.size() > base)
            chk("h_ngap_min", 32'((rise_cyc[base + 1] - fall_cyc[base]) >= int'(P_NGAP)), 32'd1);

        // Writes while busy are dropped; write held into the ready cycle is taken
        base = pulses.size();
        write_byte("e_busy", 8'h45, acc);
        toggle = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (ready) break;
            write  = 1'b1;
            wdata  = toggle ? 8'h4C : 8'h4F;
            toggle = ~toggle;
            @(negedge clk);
        end
        chk("e_ready", 32'(ready), 32'd1);
        write = 1'b1;
        wdata = 8'h21;
        @(negedge clk);
        write = 1'b0;
        wdata = 8'hFF;
        chk("same_edge_accept", 32'(ready), 32'd0);
        wait_ready("bang_ready", 500, rc);
        repeat (5) @(negedge clk);
        chk("no_queue", 32'(ready), 32'd1);
        expq = '{5'h14, 5'h15, 5'h12, 5'h11};
        cmp_pulses("busy", base);

        // Reset in the middle of an E pulse of 'A'
        write_byte("a_busy", 8'h41, acc);
        for (int k = 0; k < 50; k++) begin
            if (lcd_e) break;
            @(negedge clk);
        end
        chk("a_e_seen", 32'(lcd_e), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_e", 32'(lcd_e), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_data", 32'(lcd_data), 32'd0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = pulses.size();
        wait_ready("reinit_ready", 3000, rc);
        build_init();
        cmp_pulses("reinit", base);
        chk("reinit_ready_gap", 32'(rc - last_fall()), 32'(P_SETUP + 1 + P_1640US));

        // Two full lines of characters
        base = pulses.size();
        expq.delete();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] ch;
            ch = 8'h41 + 8'(i);
            expq.push_back({1'b1, ch[7:4]});
            expq.push_back({1'b1, ch[3:0]});
`ifdef LCD_AUTOWRAP_EN
            if (i == 15) begin
                expq.push_back(5'h0C);
                expq.push_back(5'h00);
            end
            if (i == 31) begin
                expq.push_back(5'h08);
                expq.push_back(5'h00);
            end
`endif
            write_byte("wrap_busy", ch, acc);
            wait_ready("wrap_ready", 500, rc);
        end
        cmp_pulses("wrap", base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
